dff: RTL and testbench



---
 rtl/dff.sv | 41 ++++
 tb/tb_dff.sv | 125 ++++++++++++
 2 files changed

// File: rtl/dff.sv
// ============================================================================
// Module   : dff
// Purpose  : Parameterised D flip-flop, synchronous active-high reset,
//            complementary outputs taken from a single register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dff #(
  parameter int unsigned             WIDTH       = 1,
  parameter logic [WIDTH-1:0]        RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  // qb is an inversion of the same register so the pair can never skew apart.
  assign q  = q_q;
  assign qb = ~q_q;

endmodule

`default_nettype wire

// File: tb/tb_dff.sv
// ============================================================================
// Module   : tb_dff
// Purpose  : Self-checking bench for dff, 1-bit default and 8-bit A5 variants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dff;

  logic       clk;
  logic       rst;
  logic       d1;
  logic [7:0] d8;
  logic       q1, qb1;
  logic [7:0] q8, qb8;

  int n_checks = 0;
  int n_fail   = 0;

  logic       exp1;
  logic [7:0] exp8;

  dff u_dut1 (
    .clk (clk),
    .rst (rst),
    .d   (d1),
    .q   (q1),
    .qb  (qb1)
  );

  dff #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5)
  ) u_dut8 (
    .clk (clk),
    .rst (rst),
    .d   (d8),
    .q   (q8),
    .qb  (qb8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " q1"},  {7'b0, q1},  {7'b0, exp1});
    check({tag, " qb1"}, {7'b0, qb1}, {7'b0, ~exp1});
    check({tag, " q8"},  q8,  exp8);
    check({tag, " qb8"}, qb8, ~exp8);
  endtask

  // One clock cycle: apply inputs mid-cycle, update the reference at the edge,
  // check after the edge, then wiggle inputs between edges and confirm hold.
  task automatic run_cycle(input logic r, input logic dv1, input logic [7:0] dv8,
                           input bit glitch);
    @(negedge clk);
    rst = r;
    d1  = dv1;
    d8  = dv8;
    @(posedge clk);
    exp1 = r ? 1'b0  : dv1;
    exp8 = r ? 8'hA5 : dv8;
    #1;
    check_outputs("edge");
    if (glitch) begin
      d1 = ~dv1;
      d8 = 8'($urandom);
      rst = ~r;
      #1;
      d1 = dv1;
      d8 = ~dv8;
      #1;
      check_outputs("hold");
      rst = r;
    end
  endtask

  initial begin
    rst = 1'b1;
    d1  = 1'b0;
    d8  = 8'h00;
    exp1 = 1'b0;
    exp8 = 8'hA5;

    // Reset, release with d=1, toggle d, then reset again while d=1.
    run_cycle(1'b1, 1'b0, 8'h00, 1'b0);
    run_cycle(1'b0, 1'b1, 8'h3C, 1'b0);
    run_cycle(1'b0, 1'b0, 8'hC3, 1'b0);
    run_cycle(1'b0, 1'b1, 8'h3C, 1'b0);
    run_cycle(1'b1, 1'b1, 8'hFF, 1'b1);
    run_cycle(1'b1, 1'b1, 8'h00, 1'b1);
    run_cycle(1'b1, 1'b0, 8'h5A, 1'b1);
    // First edge with rst low loads d directly.
    run_cycle(1'b0, 1'b1, 8'h3C, 1'b1);
    run_cycle(1'b0, 1'b1, 8'h3C, 1'b1);

    for (int i = 0; i < 300; i++) begin
      run_cycle(($urandom_range(0, 7) == 0), 1'($urandom), 8'($urandom),
                bit'($urandom_range(0, 1)));
    end

    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule

`default_nettype wire
